pipe_issue_scheduler: RTL and testbench
=======================================

Name: pipe_issue_scheduler

Overview:
- Shares one fixed-latency pipelined arithmetic unit (e.g. FP sqrt/div) between NUM_REQ requesters, granting round-robin.
- Tracks in-flight operations with an internal resettable delay line and captures each result exactly LATENCY cycles after issue.
- Buffers results in a small output FIFO.
- A credit check blocks issue whenever a result could find no buffer slot, so backpressure on the response side never loses data.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- DATA_WIDTH, 32, operand/result width
- LATENCY, 3, unit latency in clocks from unit_issue to valid unit_result (>=1)
- OUT_DEPTH, 8, output FIFO entries (>= LATENCY+2; power of two)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- req_valid  in  NUM_REQ  per-requester operation valid
- req_data  in  NUM_REQ*DATA_WIDTH  operands; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i]
- unit_issue  out  1  start strobe to the shared unit
- unit_operand  out  DATA_WIDTH  operand to the unit
- unit_result  in  DATA_WIDTH  unit output; valid exactly LATENCY cycles after unit_issue
- rsp_valid  out  1  response available
- rsp_data  out  DATA_WIDTH  result
- rsp_id  out  $clog2(NUM_REQ)  requester index of the result
- rsp_ready  in  1  consumer accepts the response

Behaviour:
- Reset: async, active-high. Asserting it clears:
  - rr_ptr to 0, in_flight to 0, fifo_count to 0
  - all delay-line valid bits
  - FIFO pointers.
- While reset is asserted, req_ready, unit_issue and rsp_valid are 0; unit_operand and rsp_data are 0.
- Reset mid-operation discards all in-flight and buffered results. Unit outputs returning after reset are ignored because their valid bits are cleared.
- Credit:
  - credit_ok = (in_flight + fifo_count) < OUT_DEPTH.
  - Both counts are registered, so a same-cycle FIFO pop does not free credit until the next cycle.
- Arbitration (combinational, same cycle):
  - If credit_ok and any req_valid is set, grant g = the first set req_valid at or after rr_ptr, searching upward with wrap.
  - req_ready = one-hot(g); unit_issue = 1; unit_operand = req_data[g].
  - Otherwise req_ready = 0, unit_issue = 0, and unit_operand holds its last value (don't-care).
- req_ready depends on req_valid. Requesters must not make req_valid depend on req_ready.
- On grant, rr_ptr <= (g+1) mod NUM_REQ at the next edge. rr_ptr is unchanged when there is no grant.
- Delay line:
  - {valid=unit_issue, id=g} is shifted LATENCY stages.
  - The stage output aligns with unit_result at cycle t+LATENCY for an issue at cycle t.
  - When the stage output is valid, {id, unit_result} is written into the FIFO.
- Counters:
  - in_flight increments on issue and decrements on retire (write).
  - fifo_count increments on write and decrements on pop. Pop = rsp_valid & rsp_ready.
  - Simultaneous issue+retire leaves in_flight unchanged; simultaneous write+pop leaves fifo_count unchanged.
- FIFO:
  - rsp_valid = (fifo_count != 0). rsp_data and rsp_id come from the head entry (registered storage).
  - An entry written at cycle t+LATENCY is visible from cycle t+LATENCY+1. Minimum issue-to-rsp_valid latency is LATENCY+1.
  - The credit rule guarantees the FIFO never overflows. A write to a full FIFO is impossible by construction; a simulation assertion must flag it.
- Throughput: one issue per cycle is sustained when OUT_DEPTH >= LATENCY+2 and rsp_ready is held high.
- Ordering: responses leave in issue order, regardless of requester.
- Holding rsp_ready low stops issue once in_flight + fifo_count reaches OUT_DEPTH. Issue resumes the cycle after the first pop.

Optional Feature:
- Macro: SCHED_STALL_CNT_EN.
- When defined:
  - Adds output port stall_count (16 bits).
  - stall_count increments each cycle in which any req_valid is set and credit_ok = 0.
  - It saturates at 16'hFFFF and is cleared by reset.
- When undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Single request, defaults: req_valid=4'b0001, req_data[0]=32'h1234 for one cycle.
  - Expect req_ready=4'b0001 and unit_issue in that cycle.
  - Bench unit returns 32'hABCD 3 cycles later; expect rsp_valid with rsp_data=32'hABCD, rsp_id=0 at issue+4.
- All four requesters valid continuously, rsp_ready=1:
  - Grants cycle 0,1,2,3,0,… one per clock.
  - rsp_id sequence matches grant order; no stall cycles.
- rsp_ready=0, all requesters valid:
  - Exactly 8 issues, then req_ready=0.
  - rsp_valid stays high with fifo_count=8.
  - Raise rsp_ready: 8 in-order responses, and issue resumes the cycle after the first pop.
- Round-robin fairness, requesters 1 and 3 valid continuously: grants alternate 1,3,1,3; requesters 0 and 2 are never granted.
- Reset asserted with 3 in flight and 2 buffered:
  - Outputs go to 0 immediately.
  - Bench unit results arriving after reset release produce no rsp_valid; the next grant goes to requester 0 first.
- SCHED_STALL_CNT_EN defined, rsp_ready=0, req_valid=4'b1111 for 20 cycles: stall_count = 12 (20 cycles minus 8 issues).

Source files
------------

// File: rtl/pipe_issue_scheduler_if.sv
// Request, unit and response signals of the shared-unit issue scheduler.
// slave: the scheduler; master: requesters, the arithmetic unit and the consumer.
interface pipe_issue_scheduler_if #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 32
) ();
   localparam int unsigned ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          unit_issue;
   logic [DATA_WIDTH-1:0]         unit_operand;
   logic [DATA_WIDTH-1:0]         unit_result;
   logic                          rsp_valid;
   logic [DATA_WIDTH-1:0]         rsp_data;
   logic [ID_W-1:0]               rsp_id;
   logic                          rsp_ready;

   modport master (
      output req_valid, req_data, unit_result, rsp_ready,
      input  req_ready, unit_issue, unit_operand, rsp_valid, rsp_data, rsp_id
   );

   modport slave (
      input  req_valid, req_data, unit_result, rsp_ready,
      output req_ready, unit_issue, unit_operand, rsp_valid, rsp_data, rsp_id
   );
endinterface

// File: rtl/pipe_issue_scheduler.sv
// Round-robin issue into a fixed-latency pipelined unit with credit-protected result FIFO.
// Optional SCHED_STALL_CNT_EN adds a saturating stall_count output.
module pipe_issue_scheduler #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LATENCY    = 3,
   parameter int unsigned OUT_DEPTH  = 8
) (
   input  logic clk,
   input  logic reset,
`ifdef SCHED_STALL_CNT_EN
   output logic [15:0] stall_count,
`endif
   pipe_issue_scheduler_if.slave bus
);
   localparam int unsigned ID_W  = $clog2(NUM_REQ);
   localparam int unsigned CNT_W = $clog2(OUT_DEPTH + 1);
   localparam int unsigned PTR_W = $clog2(OUT_DEPTH);

   logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d, gnt_id;
   logic                  gnt_any, credit_ok, issue, wr_en, pop;
   logic [CNT_W-1:0]      in_flight_q, in_flight_d, fifo_count_q, fifo_count_d;
   logic [CNT_W:0]        credit_sum;
   logic [DATA_WIDTH-1:0] operand_q;
   logic [DATA_WIDTH-1:0] req_op [NUM_REQ];
   logic [LATENCY-1:0]    dl_valid_q;
   logic [ID_W-1:0]       dl_id_q [LATENCY];
   logic [DATA_WIDTH-1:0] mem_data_q [OUT_DEPTH];
   logic [ID_W-1:0]       mem_id_q [OUT_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;

   // Registered counts only: a pop frees credit one cycle later.
   assign credit_sum = {1'b0, in_flight_q} + {1'b0, fifo_count_q};
   assign credit_ok  = credit_sum < (CNT_W + 1)'(OUT_DEPTH);

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         req_op[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_comb begin
      logic [ID_W:0]   sum;
      logic [ID_W-1:0] cand;
      gnt_any = 1'b0;
      gnt_id  = '0;
      sum     = '0;
      cand    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, rr_ptr_q} + (ID_W + 1)'(k);
         if (sum >= (ID_W + 1)'(NUM_REQ)) begin
            sum = sum - (ID_W + 1)'(NUM_REQ);
         end
         cand = sum[ID_W-1:0];
         if (!gnt_any && bus.req_valid[cand]) begin
            gnt_any = 1'b1;
            gnt_id  = cand;
         end
      end
   end

   assign issue            = gnt_any && credit_ok && !reset;
   assign bus.req_ready    = issue ? (NUM_REQ'(1) << gnt_id) : '0;
   assign bus.unit_issue   = issue;
   assign bus.unit_operand = issue ? req_op[gnt_id] : operand_q;

   assign wr_en         = dl_valid_q[LATENCY-1];
   assign bus.rsp_valid = (fifo_count_q != '0);
   assign pop           = bus.rsp_valid && bus.rsp_ready;
   assign bus.rsp_data  = bus.rsp_valid ? mem_data_q[rd_ptr_q] : '0;
   assign bus.rsp_id    = bus.rsp_valid ? mem_id_q[rd_ptr_q] : '0;

   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      in_flight_d  = in_flight_q;
      fifo_count_d = fifo_count_q;
      if (issue) begin
         rr_ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
      end
      if (issue && !wr_en) begin
         in_flight_d = in_flight_q + CNT_W'(1);
      end else if (!issue && wr_en) begin
         in_flight_d = in_flight_q - CNT_W'(1);
      end
      if (wr_en && !pop) begin
         fifo_count_d = fifo_count_q + CNT_W'(1);
      end else if (!wr_en && pop) begin
         fifo_count_d = fifo_count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr_q     <= '0;
         in_flight_q  <= '0;
         fifo_count_q <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         operand_q    <= '0;
         dl_valid_q   <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            dl_id_q[i] <= '0;
         end
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         in_flight_q  <= in_flight_d;
         fifo_count_q <= fifo_count_d;
         if (issue) begin
            operand_q <= req_op[gnt_id];
         end
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         // Stage LATENCY-1 lines up with unit_result for the same operation.
         dl_valid_q[0] <= issue;
         dl_id_q[0]    <= gnt_id;
         for (int i = 1; i < LATENCY; i++) begin
            dl_valid_q[i] <= dl_valid_q[i-1];
            dl_id_q[i]    <= dl_id_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_data_q[wr_ptr_q] <= bus.unit_result;
         mem_id_q[wr_ptr_q]   <= dl_id_q[LATENCY-1];
      end
   end

`ifdef SCHED_STALL_CNT_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_q <= '0;
      end else if (|bus.req_valid && !credit_ok && stall_q != 16'hFFFF) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_count = stall_q;
`endif

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (!reset && wr_en) begin
         assert (fifo_count_q < CNT_W'(OUT_DEPTH))
         else $error("pipe_issue_scheduler: write into full output fifo");
      end
   end
`endif
endmodule

// File: tb/tb_pipe_issue_scheduler.sv
// Directed bench for pipe_issue_scheduler with a 3-cycle behavioural unit.
// Covers single issue, streaming, backpressure, fairness, mid-run reset, optional stall_count.
module tb_pipe_issue_scheduler;
   logic clk;
   logic reset;
   int   total;
   int   bad;
   int   gh [16];
   int   id;
   logic [31:0] upipe [3];
`ifdef SCHED_STALL_CNT_EN
   logic [15:0] stall_count;
`endif

   pipe_issue_scheduler_if #(.NUM_REQ(4), .DATA_WIDTH(32)) bus ();

   pipe_issue_scheduler #(
      .NUM_REQ   (4),
      .DATA_WIDTH(32),
      .LATENCY   (3),
      .OUT_DEPTH (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
`ifdef SCHED_STALL_CNT_EN
      .stall_count(stall_count),
`endif
      .bus        (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] unit_fn(input logic [31:0] op);
      return (op == 32'h1234) ? 32'hABCD : ~op;
   endfunction

   function automatic logic [31:0] dval(input int i);
      return 32'hC0DE_0000 + 32'(i);
   endfunction

   // Behavioural unit: result valid exactly 3 cycles after issue, never reset.
   always @(posedge clk) begin
      upipe[0] <= bus.unit_issue ? unit_fn(bus.unit_operand) : 32'hDEAD_DEAD;
      upipe[1] <= upipe[0];
      upipe[2] <= upipe[1];
   end
   assign bus.unit_result = upipe[2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.req_valid = 4'hF;
      bus.req_data  = {dval(3), dval(2), dval(1), dval(0)};
      bus.rsp_ready = 1'b0;
      #1;
      chk("rst_ready", 32'(bus.req_ready), 32'h0);
      chk("rst_issue", 32'(bus.unit_issue), 32'h0);
      chk("rst_rspv", 32'(bus.rsp_valid), 32'h0);
      chk("rst_operand", bus.unit_operand, 32'h0);
      chk("rst_rspdata", bus.rsp_data, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      bus.req_valid = 4'h0;

      // Single request
      @(negedge clk);
      bus.req_data  = {dval(3), dval(2), dval(1), 32'h1234};
      bus.req_valid = 4'b0001;
      #1;
      chk("t1_ready", 32'(bus.req_ready), 32'h1);
      chk("t1_issue", 32'(bus.unit_issue), 32'h1);
      chk("t1_operand", bus.unit_operand, 32'h1234);
      @(negedge clk);
      bus.req_valid = 4'h0;
      #1;
      chk("t1_rspv_c1", 32'(bus.rsp_valid), 32'h0);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("t1_rspv_c3", 32'(bus.rsp_valid), 32'h0);
      @(negedge clk);
      #1;
      chk("t1_rspv_c4", 32'(bus.rsp_valid), 32'h1);
      chk("t1_rspdata", bus.rsp_data, 32'hABCD);
      chk("t1_rspid", 32'(bus.rsp_id), 32'h0);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("t1_rspv_c5", 32'(bus.rsp_valid), 32'h0);

      // Streaming, all valid; rr_ptr is 1 after the first grant
      bus.req_data = {dval(3), dval(2), dval(1), dval(0)};
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         bus.req_valid = (k < 12) ? 4'hF : 4'h0;
         #1;
         if (k < 12) begin
            gh[k] = (1 + k) % 4;
            chk("t2_grant", 32'(bus.req_ready), 32'h1 << gh[k]);
            chk("t2_issue", 32'(bus.unit_issue), 32'h1);
         end else begin
            chk("t2_idle", 32'(bus.req_ready), 32'h0);
         end
         if (k >= 4) begin
            chk("t2_rspv", 32'(bus.rsp_valid), 32'h1);
            chk("t2_rspid", 32'(bus.rsp_id), 32'(gh[k-4]));
            chk("t2_rspdata", bus.rsp_data, ~dval(gh[k-4]));
         end else begin
            chk("t2_rspv_early", 32'(bus.rsp_valid), 32'h0);
         end
      end
      @(negedge clk);
      #1;
      chk("t2_drained", 32'(bus.rsp_valid), 32'h0);

      // Backpressure: 8 credits, resume the cycle after the first pop
      bus.rsp_ready = 1'b0;
      for (int k = 0; k < 24; k++) begin
         @(negedge clk);
         bus.req_valid = (k <= 15) ? 4'hF : 4'h0;
         if (k == 14) bus.rsp_ready = 1'b1;
         #1;
         if (k < 8) begin
            chk("t3_grant", 32'(bus.req_ready), 32'h1 << ((1 + k) % 4));
         end else if (k < 15) begin
            chk("t3_stall_ready", 32'(bus.req_ready), 32'h0);
            chk("t3_stall_issue", 32'(bus.unit_issue), 32'h0);
         end else if (k == 15) begin
            chk("t3_resume", 32'(bus.req_ready), 32'h2);
         end else begin
            chk("t3_idle", 32'(bus.req_ready), 32'h0);
         end
         if (k == 12 || k == 13) begin
            chk("t3_full_rspv", 32'(bus.rsp_valid), 32'h1);
            chk("t3_full_head", 32'(bus.rsp_id), 32'h1);
         end
         if (k >= 14 && k <= 22) begin
            id = (1 + k - 14) % 4;
            chk("t3_rspv", 32'(bus.rsp_valid), 32'h1);
            chk("t3_rspid", 32'(bus.rsp_id), 32'(id));
            chk("t3_rspdata", bus.rsp_data, ~dval(id));
         end
         if (k == 23) chk("t3_drained", 32'(bus.rsp_valid), 32'h0);
      end

      // Fairness between requesters 1 and 3; rr_ptr is 2 here
      for (int k = 0; k < 13; k++) begin
         @(negedge clk);
         bus.req_valid = (k < 8) ? 4'b1010 : 4'h0;
         #1;
         if (k < 8) begin
            gh[k] = (k % 2 == 0) ? 3 : 1;
            chk("t4_grant", 32'(bus.req_ready), 32'h1 << gh[k]);
         end
         if (k >= 4 && k < 12) begin
            chk("t4_rspid", 32'(bus.rsp_id), 32'(gh[k-4]));
         end
         if (k == 12) chk("t4_drained", 32'(bus.rsp_valid), 32'h0);
      end

      // Reset with 3 in flight and 2 buffered
      bus.rsp_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         bus.req_valid = 4'b0001;
         #1;
         chk("t5_grant", 32'(bus.req_ready), 32'h1);
      end
      @(negedge clk);
      bus.req_valid = 4'h0;
      #1;
      chk("t5_buffered", 32'(bus.rsp_valid), 32'h1);
      bus.req_valid = 4'b0001;
      reset = 1'b1;
      #1;
      chk("t5_rst_ready", 32'(bus.req_ready), 32'h0);
      chk("t5_rst_issue", 32'(bus.unit_issue), 32'h0);
      chk("t5_rst_rspv", 32'(bus.rsp_valid), 32'h0);
      chk("t5_rst_rspdata", bus.rsp_data, 32'h0);
      chk("t5_rst_operand", bus.unit_operand, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      bus.req_valid = 4'h0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #1;
         chk("t5_ghost", 32'(bus.rsp_valid), 32'h0);
      end
      @(negedge clk);
      bus.req_valid = 4'hF;
      #1;
      chk("t5_first_grant", 32'(bus.req_ready), 32'h1);
      chk("t5_operand", bus.unit_operand, dval(0));
      @(negedge clk);
      bus.req_valid = 4'h0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("t5_rspv_early", 32'(bus.rsp_valid), 32'h0);
      @(negedge clk);
      #1;
      chk("t5_rspv", 32'(bus.rsp_valid), 32'h1);
      chk("t5_rspdata", bus.rsp_data, ~dval(0));
      chk("t5_rspid", 32'(bus.rsp_id), 32'h0);

`ifdef SCHED_STALL_CNT_EN
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      bus.rsp_ready = 1'b0;
      #1;
      chk("t6_stall_rst", 32'(stall_count), 32'h0);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         bus.req_valid = 4'hF;
      end
      @(negedge clk);
      bus.req_valid = 4'h0;
      #1;
      chk("t6_stall_count", 32'(stall_count), 32'd12);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
